// File: rtl/cmd_pkg.sv
// Shared constants for the command-line decoder: ASCII codes, keywords,
// command codes, line-state encoding and the keyword lookup helper.
package cmd_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  localparam logic [23:0] KW_ADD = "ADD";
  localparam logic [23:0] KW_SUB = "SUB";
  localparam logic [23:0] KW_MUL = "MUL";
  localparam logic [23:0] KW_CLR = "CLR";

  localparam logic [1:0] CMD_ADD = 2'd0;
  localparam logic [1:0] CMD_SUB = 2'd1;
  localparam logic [1:0] CMD_MUL = 2'd2;
  localparam logic [1:0] CMD_CLR = 2'd3;

  localparam int KW_LEN = 3;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_OVERFLOW = 2'd2
  } line_state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } kw_match_t;

  // Maps a three-character (already upper-cased) word to its command code.
  function automatic kw_match_t kw_lookup(input logic [23:0] word);
    kw_match_t m;
    m.hit  = 1'b1;
    m.code = CMD_ADD;
    case (word)
      KW_ADD:  m.code = CMD_ADD;
      KW_SUB:  m.code = CMD_SUB;
      KW_MUL:  m.code = CMD_MUL;
      KW_CLR:  m.code = CMD_CLR;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cmd_char_class.sv
// Combinational character classifier: folds lowercase to uppercase and flags
// printable, erase (BS/DEL) and carriage-return characters.
module cmd_char_class
  import cmd_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [7:0] out_folded,
  output logic       is_print,
  output logic       is_bs,
  output logic       is_cr
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    out_folded = in_char;
    is_print   = 1'b0;
    is_bs      = 1'b0;
    is_cr      = 1'b0;

    if (in_char >= 8'h61 && in_char <= 8'h7A) begin
      out_folded = in_char - 8'h20;
    end

    case (in_char)
      ASCII_CR:            is_cr = 1'b1;
      ASCII_BS, ASCII_DEL: is_bs = 1'b1;
      ASCII_SP, ASCII_LF:  ;  // whitespace carries no meaning in a command line
      default:             is_print = (in_char > ASCII_SP) && (in_char < ASCII_DEL);
    endcase
  end

endmodule

// File: rtl/cmd_line_decoder.sv
// Assembles one ASCII command line and, on Enter, matches it against the
// ADD/SUB/MUL/CLR keywords, emitting a command strobe or an error strobe.
module cmd_line_decoder
  import cmd_pkg::*;
#(
  parameter int MAX_LEN = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] in_char,
  input  logic       in_valid,
  output logic [1:0] out_cmd,
  output logic       out_valid,
  output logic       out_err,
  output logic       busy
);

  localparam int             CW          = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0]  LP_FULL     = CW'(MAX_LEN);
  localparam logic [CW-1:0]  LP_KW_LEN   = CW'(KW_LEN);
  localparam logic [CW-1:0]  LP_ONE      = CW'(1);

  logic [7:0]    w_folded;
  logic          w_is_print;
  logic          w_is_bs;
  logic          w_is_cr;
  logic          w_store;
  logic [23:0]   w_line;
  kw_match_t     w_kw;

  line_state_e   r_state;
  logic [CW-1:0] r_count;
  logic [7:0]    r_buf [KW_LEN];
  logic [1:0]    r_cmd;
  logic          r_valid;
  logic          r_err;
  logic          r_busy;

  cmd_char_class u_char_class (
    .in_char    (in_char),
    .out_folded (w_folded),
    .is_print   (w_is_print),
    .is_bs      (w_is_bs),
    .is_cr      (w_is_cr)
  );

  // Only the first three characters can ever form a keyword; longer lines are
  // rejected on length alone, so positions beyond that are never stored.
  assign w_store = in_valid && w_is_print && (r_state != ST_OVERFLOW) && (r_count < LP_KW_LEN);
  assign w_line  = {r_buf[0], r_buf[1], r_buf[2]};
  assign w_kw    = kw_lookup(w_line);

  // NOTE: the character buffer has no reset; its contents are only read when
  // r_count says they were written since the last reset or Enter.
  always_ff @(posedge CLK) begin
    if (w_store) begin
      r_buf[r_count[1:0]] <= w_folded;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_cmd   <= CMD_ADD;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (in_valid) begin
        if (w_is_cr) begin
          r_state <= ST_EMPTY;
          r_count <= '0;
          r_busy  <= 1'b0;
          case (r_state)
            ST_OVERFLOW: r_err <= 1'b1;
            ST_COLLECT: begin
              if (r_count == LP_KW_LEN && w_kw.hit) begin
                r_valid <= 1'b1;
                r_cmd   <= w_kw.code;
              end else begin
                r_err   <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (w_is_bs) begin
          if (r_state == ST_COLLECT) begin
            r_count <= r_count - LP_ONE;
            if (r_count == LP_ONE) begin
              r_state <= ST_EMPTY;
              r_busy  <= 1'b0;
            end
          end
        end else if (w_is_print && r_state != ST_OVERFLOW) begin
          r_busy <= 1'b1;
          if (r_count == LP_FULL) begin
            r_state <= ST_OVERFLOW;
          end else begin
            r_state <= ST_COLLECT;
            r_count <= r_count + LP_ONE;
          end
        end
      end
    end
  end

  assign out_cmd   = r_cmd;
  assign out_valid = r_valid;
  assign out_err   = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cmd_line_decoder.sv
// Self-checking bench for cmd_line_decoder: a table of command lines with
// expected outcomes feeds a scoreboard, plus hand-written busy/reset sequences.
module tb_cmd_line_decoder;
  import cmd_pkg::*;

  typedef enum int { K_NONE = 0, K_VALID = 1, K_ERR = 2, K_BOTH = 3 } kind_e;

  typedef struct {
    kind_e      kind;
    logic [1:0] cmd;
  } exp_t;

  typedef struct {
    string      name;
    string      line;
    kind_e      kind;
    logic [1:0] cmd;
  } vec_t;

  logic       CLK      = 1'b0;
  logic       RST_N    = 1'b0;
  logic [7:0] in_char  = 8'h00;
  logic       in_valid = 1'b0;
  logic [1:0] out_cmd;
  logic       out_valid;
  logic       out_err;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  exp_t       sb[$];
  logic [1:0] model_cmd = CMD_ADD;
  vec_t       vecs[$];

  cmd_line_decoder #(.MAX_LEN(4)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_char   (in_char),
    .in_valid  (in_valid),
    .out_cmd   (out_cmd),
    .out_valid (out_valid),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Called just after a falling edge: compares any strobe against the
  // scoreboard head and checks that out_cmd holds the last accepted command.
  task automatic observe(input string tag);
    int   k;
    exp_t e;
    k = (out_valid && out_err) ? K_BOTH : out_valid ? K_VALID : out_err ? K_ERR : K_NONE;
    if (k != K_NONE) begin
      if (sb.size() == 0) begin
        check({tag, " unexpected_pulse"}, k, K_NONE);
      end else begin
        e = sb.pop_front();
        check({tag, " pulse_kind"}, k, e.kind);
        if (e.kind == K_VALID) model_cmd = e.cmd;
      end
    end
    check({tag, " out_cmd"}, int'(out_cmd), int'(model_cmd));
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    observe(tag);
  endtask

  // Drives one character per cycle; the first CR of the line carries the
  // expected outcome, any further CR must produce nothing.
  task automatic run_line(input string name, input string line, input kind_e kind,
                          input logic [1:0] cmd);
    bit   first_cr;
    byte  c;
    exp_t e;
    first_cr = 1'b1;
    for (int i = 0; i < line.len(); i++) begin
      c        = line[i];
      in_char  = c;
      in_valid = 1'b1;
      if (c == ASCII_CR && first_cr) begin
        first_cr = 1'b0;
        if (kind != K_NONE) begin
          e.kind = kind;
          e.cmd  = cmd;
          sb.push_back(e);
        end
      end
      tick(name);
    end
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) tick(name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4 && sb.size() != 0; i++) tick(name);
    check({name, " pending_pulses"}, sb.size(), 0);
  endtask

  initial begin
    vecs.push_back('{"add_lower",     "add\015",                       K_VALID, CMD_ADD});
    vecs.push_back('{"mul",           "MUL\015",                       K_VALID, CMD_MUL});
    vecs.push_back('{"clr_mixed",     "Clr\015",                       K_VALID, CMD_CLR});
    vecs.push_back('{"sux_bs_b",      "SUX\010B\015",                  K_VALID, CMD_SUB});
    vecs.push_back('{"xyz",           "XYZ\015",                       K_ERR,   CMD_ADD});
    vecs.push_back('{"overflow",      "ABCDE\015",                     K_ERR,   CMD_ADD});
    vecs.push_back('{"add_after_ovf", "ADD\015",                       K_VALID, CMD_ADD});
    vecs.push_back('{"cr_alone",      "\015",                          K_NONE,  CMD_ADD});
    vecs.push_back('{"bs_cr",         "\010\015",                      K_NONE,  CMD_ADD});
    vecs.push_back('{"sp_lf_cr",      " \012\015",                     K_NONE,  CMD_ADD});
    vecs.push_back('{"addx",          "ADDX\015",                      K_ERR,   CMD_ADD});
    vecs.push_back('{"ad",            "AD\015",                        K_ERR,   CMD_ADD});
    vecs.push_back('{"full_no_ovf",   "ABCD\015",                      K_ERR,   CMD_ADD});
    vecs.push_back('{"del_sub",       "sUx\177b\015",                  K_VALID, CMD_SUB});
    vecs.push_back('{"ovf_ignores_bs","ABCDE\010\010\010\010\015",     K_ERR,   CMD_ADD});
    vecs.push_back('{"bs_from_full",  "ABCD\010E\015",                 K_ERR,   CMD_ADD});
    vecs.push_back('{"bs_to_empty",   "ABC\010\010\010\010ADD\015",    K_VALID, CMD_ADD});
    vecs.push_back('{"double_cr",     "mul\015\015",                   K_VALID, CMD_MUL});
    vecs.push_back('{"ctl_ignored",   "SUB\001\015",                   K_VALID, CMD_SUB});
    vecs.push_back('{"spaced_clr",    "c l r\015",                     K_VALID, CMD_CLR});

    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset out_cmd",   int'(out_cmd),   0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_err",   int'(out_err),   0);
    check("reset busy",      int'(busy),      0);
    RST_N = 1'b1;
    idle(2, "post_reset");

    foreach (vecs[i]) begin
      run_line(vecs[i].name, vecs[i].line, vecs[i].kind, vecs[i].cmd);
      idle(3, {vecs[i].name, " gap"});
      drain(vecs[i].name);
      check({vecs[i].name, " busy_after"}, int'(busy), 0);
    end

    // busy tracks a partial line and drops when erased back to empty.
    run_line("busy_q", "Q", K_NONE, CMD_ADD);
    check("busy_q collect", int'(busy), 1);
    run_line("busy_q_bs", "\010", K_NONE, CMD_ADD);
    check("busy_q erased", int'(busy), 0);
    run_line("busy_q_bs2", "\177", K_NONE, CMD_ADD);
    check("busy_q extra_del", int'(busy), 0);

    // Overflow holds busy through erase attempts until Enter.
    run_line("ovf_seq", "ABCDE", K_NONE, CMD_ADD);
    check("ovf_seq busy", int'(busy), 1);
    run_line("ovf_seq_bs", "\010\010\010\010\010", K_NONE, CMD_ADD);
    check("ovf_seq busy_after_bs", int'(busy), 1);
    run_line("ovf_seq_cr", "\015", K_ERR, CMD_ADD);
    check("ovf_seq busy_after_cr", int'(busy), 0);
    run_line("ovf_seq_add", "ADD\015", K_VALID, CMD_ADD);
    drain("ovf_seq");

    // Mid-line reset clears outputs immediately and discards the partial line.
    run_line("pre_rst_clr", "CLR\015", K_VALID, CMD_CLR);
    run_line("pre_rst_su", "SU", K_NONE, CMD_ADD);
    #2 RST_N = 1'b0;
    #1;
    check("midrst out_cmd",   int'(out_cmd),   0);
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst out_err",   int'(out_err),   0);
    check("midrst busy",      int'(busy),      0);
    model_cmd = CMD_ADD;
    sb.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    idle(1, "midrst_release");
    run_line("post_rst_b", "B\015", K_ERR, CMD_ADD);
    idle(2, "post_rst_b gap");
    drain("post_rst_b");
    check("post_rst_b busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_line_decoder.md
Name: cmd_line_decoder

Overview:
- Receives a stream of ASCII characters from the serial/keyboard front end and assembles one command line.
- On Enter, matches the line against four fixed keywords and emits a 2-bit command code with a one-cycle valid strobe.
- Sits directly upstream of the 2-bit command register; out_cmd feeds that register's in_dat.
- Rejected lines raise a one-cycle error strobe instead.

Parameters:
- MAX_LEN, 4: line buffer depth in characters; must be >= 3.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- in_char  in  8  ASCII character, sampled when in_valid=1.
- in_valid  in  1  character strobe; one character per cycle max, no backpressure.
- out_cmd  out  2  last accepted command code: ADD=0, SUB=1, MUL=2, CLR=3.
- out_valid  out  1  one-cycle pulse; out_cmd updated on this cycle.
- out_err  out  1  one-cycle pulse; unknown keyword or overflowed line.
- busy  out  1  high while the buffer holds >=1 character or state=OVERFLOW.

Behaviour:
- Reset, asynchronous on RST_N=0:
  - out_cmd=0, out_valid=0, out_err=0, busy=0.
  - count=0, state=EMPTY, buffer contents don't-care.
  - Reset mid-line discards the partial line.
- States and transitions:
  - EMPTY: count=0.
  - COLLECT: 1..MAX_LEN chars held.
  - OVERFLOW: line too long; printable chars and BS/DEL discarded until CR.
- Character classes, applied only when in_valid=1:
  - Lowercase 0x61-0x7A is folded to uppercase (subtract 0x20) before storage or compare.
  - Space 0x20, LF 0x0A and all other control chars (except BS, DEL, CR) are ignored, with no state change.
  - Printable 0x21-0x7E:
    - If count<MAX_LEN: store at buffer[count], count+1, state=COLLECT.
    - If count==MAX_LEN: state=OVERFLOW, count unchanged.
  - BS 0x08 or DEL 0x7F:
    - COLLECT: count-1; if count reaches 0, state=EMPTY.
    - EMPTY: no effect.
    - OVERFLOW: no effect.
  - CR 0x0D:
    - EMPTY: no pulse.
    - OVERFLOW: out_err pulse.
    - COLLECT with count==3 and buffer matches "ADD"/"SUB"/"MUL"/"CLR": out_valid pulse, out_cmd = code.
    - Any other COLLECT case: out_err pulse, out_cmd unchanged.
    - In every case count=0, state=EMPTY after the edge.
- Latency: CR sampled at edge N; out_valid/out_err are high for exactly the cycle after edge N, i.e. registered and cleared at edge N+1.
- A new character at edge N+1 is accepted normally. Back-to-back CR produces at most one pulse per non-empty line.
- out_valid and out_err are never high together. out_cmd changes only with out_valid and holds between commands.
- busy is registered; it reflects the post-edge state.
- Compare is exact and length-sensitive: "ADDX" and "AD" are errors.

Decomposition:
- Package cmd_pkg:
  - ASCII constants: CR, LF, BS, DEL, SP.
  - Keyword constants, 3 bytes each.
  - Command-code localparams CMD_ADD..CMD_CLR, 2 bits.
  - State encoding for EMPTY/COLLECT/OVERFLOW.
- One sub-module, cmd_char_class (combinational):
  - Input: in_char.
  - Outputs: folded char plus class flags is_print, is_bs, is_cr.
- FSM, buffer and comparator stay in cmd_line_decoder.

Test Plan:
- "add",CR (0x61,0x64,0x64,0x0D) one per cycle -> out_valid=1 for one cycle after CR, out_cmd=0, out_err=0, busy=0 after.
- "MUL",CR then "Clr",CR with idle gaps -> out_cmd=2 then 3; two out_valid pulses; out_cmd holds 2 between them.
- "SUX",BS,"B",CR -> out_cmd=1, out_valid pulse; "XYZ",CR -> out_err pulse, out_cmd stays 1.
- "ABCDE",CR (MAX_LEN=4) -> OVERFLOW after 'E', busy=1; CR gives out_err pulse; then "ADD",CR gives out_cmd=0.
- CR alone, then BS,CR, then " ",LF,CR -> no out_valid/out_err pulses, busy stays 0.
- "SU" then RST_N=0 mid-cycle -> outputs 0 immediately; after release "B",CR -> out_err (buffer cleared, not "SUB").
